// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: turns raw DE2 pushbuttons and slide switches into a 16-bit
// entry value for the hex display path. Each key is synchronised, debounced and
// edge-detected. Each accepted press triggers one action on the entry register.
//
// Ports:
//   CLOCK_50     in   system clock, all state changes on its rising edge
//   RESET        in   synchronous active-high reset
//   KEY[3:0]     in   raw pushbuttons, active-low, asynchronous
//   SW[15:0]     in   slide switches, quasi-static, used unsynchronised
//   VALUE[15:0]  out  entry register
//   VALUE_VALID  out  set by load/shift, cleared by clear
//   KEY_LEVEL    out  debounced key state, active-high
//   KEY_PRESSED  out  one-cycle pulse per accepted press
//
// Key actions, in priority order when pulses coincide:
//   KEY0 clear, KEY3 load SW, KEY2 shift in SW[3:0], KEY1 increment.

module key_entry_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [3:0]  KEY,
    input  logic [15:0] SW,
    output logic [15:0] VALUE,
    output logic        VALUE_VALID,
    output logic [3:0]  KEY_LEVEL,
    output logic [3:0]  KEY_PRESSED
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       level_q;
    logic [3:0]       level_d;
    logic [3:0]       level_prev_q;
    logic [3:0]       pressed_q;
    logic [3:0]       pressed_d;
    logic [15:0]      value_q;
    logic [15:0]      value_d;
    logic             valid_q;
    logic             valid_d;

    // Debounce: count consecutive synchronised samples that disagree with the
    // accepted level; any agreeing sample restarts the run.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                // Raw key is active-low, so sync2 != level means "stable".
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                level_d[i] = ~level_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Rising edge of the debounced level only; releases never pulse.
    always_comb begin
        pressed_d = level_q & ~level_prev_q;
    end

    always_comb begin
        value_d = value_q;
        valid_d = valid_q;
        if (pressed_q[0]) begin
            value_d = 16'h0000;
            valid_d = 1'b0;
        end else if (pressed_q[3]) begin
            value_d = SW;
            valid_d = 1'b1;
        end else if (pressed_q[2]) begin
            value_d = {value_q[11:0], SW[3:0]};
            valid_d = 1'b1;
        end else if (pressed_q[1]) begin
            value_d = value_q + 16'd1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1_q      <= 4'hF;
            sync2_q      <= 4'hF;
            level_q      <= 4'h0;
            level_prev_q <= 4'h0;
            pressed_q    <= 4'h0;
            value_q      <= 16'h0000;
            valid_q      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= KEY;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            pressed_q    <= pressed_d;
            value_q      <= value_d;
            valid_q      <= valid_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign VALUE       = value_q;
    assign VALUE_VALID = valid_q;
    assign KEY_LEVEL   = level_q;
    assign KEY_PRESSED = pressed_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
module tb_key_entry_ctrl;

    localparam int unsigned D = 4;

    logic        CLOCK_50 = 1'b0;
    logic        RESET    = 1'b1;
    logic [3:0]  KEY      = 4'hF;
    logic [15:0] SW       = 16'h0000;
    logic [15:0] VALUE;
    logic        VALUE_VALID;
    logic [3:0]  KEY_LEVEL;
    logic [3:0]  KEY_PRESSED;

    key_entry_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .KEY        (KEY),
        .SW         (SW),
        .VALUE      (VALUE),
        .VALUE_VALID(VALUE_VALID),
        .KEY_LEVEL  (KEY_LEVEL),
        .KEY_PRESSED(KEY_PRESSED)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: histories indexed by edge number since reset release.
    logic [3:0]  m_key [$];   // KEY applied at each edge
    logic [3:0]  m_seen[$];   // raw level the debouncer observes at each edge
    logic [3:0]  m_lvl [$];   // debounced level after each edge
    logic [3:0]  m_prs [$];   // press pulses after each edge
    int          m_last[4];   // edge of last level toggle (-1 = reset)
    logic [15:0] m_value;
    logic        m_valid;
    logic [3:0]  m_cur_lvl;
    logic [3:0]  m_cur_prs;

    task automatic model_step(input logic rst, input logic [3:0] key, input logic [15:0] sw);
        int         n;
        logic [3:0] seen, prev, nxt, prs, act;
        bit         all_diff;
        if (rst) begin
            m_key.delete();
            m_seen.delete();
            m_lvl.delete();
            m_prs.delete();
            for (int i = 0; i < 4; i++) m_last[i] = -1;
            m_value   = 16'h0000;
            m_valid   = 1'b0;
            m_cur_lvl = 4'h0;
            m_cur_prs = 4'h0;
            return;
        end
        n = m_key.size();
        m_key.push_back(key);
        // Two-stage synchroniser: the debouncer sees KEY from two edges ago,
        // and "released" for the first two edges after reset.
        seen = (n >= 2) ? m_key[n-2] : 4'hF;
        m_seen.push_back(seen);
        prev = (n >= 1) ? m_lvl[n-1] : 4'h0;
        nxt  = prev;
        for (int i = 0; i < 4; i++) begin
            // Toggle once the last D observed samples all differ from the
            // released/pressed state implied by the level, counted since the
            // previous toggle.
            if (n - m_last[i] >= int'(D)) begin
                all_diff = 1'b1;
                for (int k = n - int'(D) + 1; k <= n; k++) begin
                    if (m_seen[k][i] == ~prev[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    nxt[i]    = ~prev[i];
                    m_last[i] = n;
                end
            end
        end
        m_lvl.push_back(nxt);
        prs = ((n >= 1) ? m_lvl[n-1] : 4'h0) & ~((n >= 2) ? m_lvl[n-2] : 4'h0);
        act = (n >= 1) ? m_prs[n-1] : 4'h0;
        m_prs.push_back(prs);
        if (act[0]) begin
            m_value = 16'h0000;
            m_valid = 1'b0;
        end else if (act[3]) begin
            m_value = sw;
            m_valid = 1'b1;
        end else if (act[2]) begin
            m_value = {m_value[11:0], sw[3:0]};
            m_valid = 1'b1;
        end else if (act[1]) begin
            m_value = m_value + 16'd1;
        end
        m_cur_lvl = nxt;
        m_cur_prs = prs;
    endtask

    task automatic cycle(input logic rst, input logic [3:0] key, input logic [15:0] sw);
        RESET = rst;
        KEY   = key;
        SW    = sw;
        @(posedge CLOCK_50);
        model_step(rst, key, sw);
        #1;
        check("value",   VALUE,                  m_value);
        check("valid",   {15'b0, VALUE_VALID},   {15'b0, m_valid});
        check("level",   {12'b0, KEY_LEVEL},     {12'b0, m_cur_lvl});
        check("pressed", {12'b0, KEY_PRESSED},   {12'b0, m_cur_prs});
    endtask

    task automatic press(input logic [3:0] key, input logic [15:0] sw);
        repeat (10) cycle(1'b0, key, sw);
        repeat (10) cycle(1'b0, 4'hF, sw);
    endtask

    initial begin
        int          pulses;
        logic [3:0]  rkey;
        logic [15:0] rsw;
        logic        rrst;
        int          hold;
        logic        bounce [15];

        // 1: reset, idle keys
        repeat (2) cycle(1'b1, 4'hF, 16'hBEEF);
        for (int j = 0; j < 20; j++) begin
            cycle(1'b0, 4'hF, 16'hBEEF);
            check("s1_pressed", {12'b0, KEY_PRESSED}, 16'h0000);
        end
        check("s1_value", VALUE, 16'h0000);
        check("s1_valid", {15'b0, VALUE_VALID}, 16'h0000);

        // 2: clean KEY3 press loads SW
        for (int j = 0; j < 20; j++) begin
            cycle(1'b0, 4'b0111, 16'h1234);
            check("s2_level3", {15'b0, KEY_LEVEL[3]}, {15'b0, (j >= 5)});
            check("s2_press3", {15'b0, KEY_PRESSED[3]}, {15'b0, (j == 6)});
            check("s2_value", VALUE, (j >= 7) ? 16'h1234 : 16'h0000);
        end
        for (int j = 0; j < 20; j++) begin
            cycle(1'b0, 4'hF, 16'h1234);
            check("s2_rel_press", {12'b0, KEY_PRESSED}, 16'h0000);
        end
        check("s2_value_hold", VALUE, 16'h1234);
        check("s2_valid", {15'b0, VALUE_VALID}, 16'h0001);

        // 3: glitch rejection, then bounce accepted only after a full run
        repeat (3) cycle(1'b0, 4'b1011, 16'h1234);
        for (int j = 0; j < 10; j++) begin
            cycle(1'b0, 4'hF, 16'h1234);
            check("s3_glitch_level", {12'b0, KEY_LEVEL}, 16'h0000);
            check("s3_glitch_press", {12'b0, KEY_PRESSED}, 16'h0000);
        end
        check("s3_glitch_value", VALUE, 16'h1234);
        for (int j = 0; j < 15; j++) bounce[j] = 1'b0;
        bounce[2] = 1'b1;
        for (int j = 0; j < 15; j++) begin
            cycle(1'b0, {1'b1, bounce[j], 2'b11}, 16'h1234);
            check("s3_bounce_level2", {15'b0, KEY_LEVEL[2]}, {15'b0, (j >= 8)});
        end
        repeat (12) cycle(1'b0, 4'hF, 16'h1234);
        check("s3_shift", VALUE, 16'h2344);

        // 4: increment wraps, shift twice
        press(4'b0111, 16'hFFFF);
        check("s4_load", VALUE, 16'hFFFF);
        press(4'b1101, 16'hFFFF);
        check("s4_wrap", VALUE, 16'h0000);
        check("s4_valid", {15'b0, VALUE_VALID}, 16'h0001);
        press(4'b1011, 16'h000A);
        press(4'b1011, 16'h000A);
        check("s4_shift2", VALUE, 16'h00AA);

        // 5: KEY0 and KEY3 together, clear wins
        for (int j = 0; j < 10; j++) begin
            cycle(1'b0, 4'b0110, 16'h1357);
            check("s5_pressed", {12'b0, KEY_PRESSED}, (j == 6) ? 16'h0009 : 16'h0000);
        end
        repeat (10) cycle(1'b0, 4'hF, 16'h1357);
        check("s5_value", VALUE, 16'h0000);
        check("s5_valid", {15'b0, VALUE_VALID}, 16'h0000);

        // 6a: KEY3 held through reset
        repeat (3) cycle(1'b1, 4'b0111, 16'h5A5A);
        pulses = 0;
        for (int j = 0; j < 12; j++) begin
            cycle(1'b0, 4'b0111, 16'h5A5A);
            if (KEY_PRESSED[3]) pulses++;
            check("s6_press3", {15'b0, KEY_PRESSED[3]}, {15'b0, (j == 6)});
        end
        check("s6_pulses", 16'(pulses), 16'd1);
        check("s6_value", VALUE, 16'h5A5A);
        repeat (10) cycle(1'b0, 4'hF, 16'h5A5A);

        // 6b: reset mid-debounce discards the partial count
        for (int j = 0; j < 4; j++) begin
            cycle(1'b0, 4'b1101, 16'h5A5A);
            check("s6_pre_level", {12'b0, KEY_LEVEL}, 16'h0000);
        end
        cycle(1'b1, 4'b1101, 16'h5A5A);
        for (int j = 0; j < 12; j++) begin
            cycle(1'b0, 4'b1101, 16'h5A5A);
            check("s6_post_level1", {15'b0, KEY_LEVEL[1]}, {15'b0, (j >= 5)});
            check("s6_post_value", VALUE, (j >= 7) ? 16'h0001 : 16'h0000);
        end
        repeat (10) cycle(1'b0, 4'hF, 16'h5A5A);

        // Randomised segments against the model
        for (int s = 0; s < 300; s++) begin
            rrst = ($urandom_range(0, 39) == 0);
            rkey = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            rsw  = 16'($urandom);
            hold = rrst ? 1 : int'($urandom_range(1, 8));
            repeat (hold) cycle(rrst, rkey, rsw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
